// File: rtl/iic_pkg.sv
// Shared IIC definitions: FSM state encoding and engine field widths.
// Pure declarations, no logic or latency.
// Used by the transaction arbiter and the AXI-lite IIC bridge.
package iic_pkg;

    localparam int IIC_DEV_ADDR_W  = 7;
    localparam int IIC_WORD_ADDR_W = 8;
    localparam int IIC_DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } iic_state_t;

endpackage

// File: rtl/iic_rr_arbiter.sv
// Round-robin pick: first set request searching upward from last+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/iic_txn_arbiter.sv
// Shares one IIC byte engine between N_REQ requesters, one transaction in flight.
// Latency: req_valid seen -> req_ready next cycle -> engine enable the cycle after.
// Backpressure: requesters hold req_valid until their req_ready pulse; others wait in RR order.
module iic_txn_arbiter
    import iic_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0]                    req_rnw,
    input  logic [IIC_DEV_ADDR_W*N_REQ-1:0]     req_dev_addr,
    input  logic [IIC_WORD_ADDR_W*N_REQ-1:0]    req_word_addr,
    input  logic [IIC_DATA_W*N_REQ-1:0]         req_wdata,
    output logic [N_REQ-1:0]                    req_ready,
    output logic [N_REQ-1:0]                    rsp_valid,
    output logic [IIC_DATA_W-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic                                iic_send_en,
    output logic                                iic_recv_en,
    output logic [IIC_DEV_ADDR_W-1:0]           iic_dev_addr,
    output logic [IIC_WORD_ADDR_W-1:0]          iic_word_addr,
    output logic [IIC_DATA_W-1:0]               iic_write_data,
    input  logic                                iic_done,
    input  logic [IIC_DATA_W-1:0]               iic_read_data
);

    localparam int IW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    iic_state_t     state;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  last_idx;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req  (req_valid),
        .last (last_idx),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            gnt_idx        <= '0;
            last_idx       <= IW'(N_REQ - 1);
            cnt            <= '0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            iic_send_en    <= 1'b0;
            iic_recv_en    <= 1'b0;
            iic_dev_addr   <= '0;
            iic_word_addr  <= '0;
            iic_write_data <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_idx   <= arb_idx;
                        req_ready <= arb_gnt;
                        state     <= ST_LATCH;
                    end
                end
                // Fields are captured at the end of the ready cycle, while the requester still holds them.
                ST_LATCH: begin
                    iic_dev_addr   <= req_dev_addr[gnt_idx*IIC_DEV_ADDR_W +: IIC_DEV_ADDR_W];
                    iic_word_addr  <= req_word_addr[gnt_idx*IIC_WORD_ADDR_W +: IIC_WORD_ADDR_W];
                    iic_write_data <= req_wdata[gnt_idx*IIC_DATA_W +: IIC_DATA_W];
                    iic_recv_en    <= req_rnw[gnt_idx];
                    iic_send_en    <= ~req_rnw[gnt_idx];
                    last_idx       <= gnt_idx;
                    cnt            <= '0;
                    state          <= ST_RUN;
                end
                ST_RUN: begin
                    if (iic_done) begin
                        rsp_valid   <= N_REQ'(1) << gnt_idx;
                        rsp_rdata   <= iic_recv_en ? iic_read_data : '0;
                        rsp_err     <= 1'b0;
                        iic_send_en <= 1'b0;
                        iic_recv_en <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid   <= N_REQ'(1) << gnt_idx;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        iic_send_en <= 1'b0;
                        iic_recv_en <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_txn_arbiter.sv
// Directed bench: default-timeout instance for arbitration/data paths, 16-cycle instance for timeouts.
module tb_iic_txn_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default timeout
    logic [3:0]  req_valid = '0, req_rnw = '0;
    logic [27:0] req_dev_addr = '0;
    logic [31:0] req_word_addr = '0, req_wdata = '0;
    logic [3:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, send_en, recv_en;
    logic [6:0]  dev;
    logic [7:0]  word, wd;
    logic        done = 1'b0;
    logic [7:0]  rd = '0;

    // Instance B: TIMEOUT_CYCLES = 16
    logic [3:0]  b_req_valid = '0, b_req_rnw = '0;
    logic [27:0] b_req_dev_addr = '0;
    logic [31:0] b_req_word_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_ready, b_rsp_valid;
    logic [7:0]  b_rsp_rdata;
    logic        b_rsp_err, b_send_en, b_recv_en;
    logic [6:0]  b_dev;
    logic [7:0]  b_word, b_wd;
    logic        b_done = 1'b0;
    logic [7:0]  b_rd = '0;

    iic_txn_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_dev_addr(req_dev_addr),
        .req_word_addr(req_word_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .iic_send_en(send_en), .iic_recv_en(recv_en), .iic_dev_addr(dev),
        .iic_word_addr(word), .iic_write_data(wd), .iic_done(done), .iic_read_data(rd)
    );

    iic_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset(rst),
        .req_valid(b_req_valid), .req_rnw(b_req_rnw), .req_dev_addr(b_req_dev_addr),
        .req_word_addr(b_req_word_addr), .req_wdata(b_req_wdata),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .iic_send_en(b_send_en), .iic_recv_en(b_recv_en), .iic_dev_addr(b_dev),
        .iic_word_addr(b_word), .iic_write_data(b_wd), .iic_done(b_done), .iic_read_data(b_rd)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy_a(output logic [3:0] got);
        for (int c = 0; c < 20; c++) begin
            if (req_ready != 4'b0) break;
            tick();
        end
        got = req_ready;
    endtask

    task automatic wait_rdy_b(output logic [3:0] got);
        for (int c = 0; c < 20; c++) begin
            if (b_req_ready != 4'b0) break;
            tick();
        end
        got = b_req_ready;
    endtask

    initial begin
        logic [3:0] got;
        logic [3:0] exp_oh;
        logic       seen;
        int en_cnt;
        int lowc;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_enables", {send_en, recv_en}, 0);
        chk("rst_rsp", {rsp_err, rsp_rdata}, 0);
        chk("rst_fields", {dev, word, wd}, 0);
        chk("rst_b_enables", {b_send_en, b_recv_en}, 0);

        // 1: req0 write, done after 100 enable cycles
        req_dev_addr[0 +: 7] = 7'h50;
        req_word_addr[0 +: 8] = 8'h10;
        req_wdata[0 +: 8] = 8'hA5;
        req_rnw[0] = 1'b0;
        req_valid[0] = 1'b1;
        tick();
        chk("t1_ready_latency", req_ready, 4'b0001);
        req_valid[0] = 1'b0;
        tick();
        chk("t1_ready_pulse", req_ready, 0);
        chk("t1_enables", {send_en, recv_en}, 2'b10);
        chk("t1_fields", {dev, word, wd}, {7'h50, 8'h10, 8'hA5});
        en_cnt = 0;
        repeat (99) begin
            en_cnt += int'(send_en);
            tick();
        end
        en_cnt += int'(send_en);
        done = 1'b1; rd = 8'hEE;
        tick();
        done = 1'b0;
        chk("t1_send_cycles", en_cnt, 100);
        chk("t1_en_off", {send_en, recv_en}, 0);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp", {rsp_err, rsp_rdata}, 0);
        tick();
        chk("t1_rsp_pulse", rsp_valid, 0);
        chk("t1_fields_hold", {dev, word, wd}, {7'h50, 8'h10, 8'hA5});

        // 2: req2 read, read data returned
        req_dev_addr[14 +: 7] = 7'h68;
        req_word_addr[16 +: 8] = 8'h75;
        req_rnw[2] = 1'b1;
        req_valid[2] = 1'b1;
        wait_rdy_a(got);
        chk("t2_ready", got, 4'b0100);
        req_valid[2] = 1'b0;
        tick();
        chk("t2_enables", {send_en, recv_en}, 2'b01);
        chk("t2_fields", {dev, word}, {7'h68, 8'h75});
        repeat (5) tick();
        done = 1'b1; rd = 8'h3C;
        tick();
        done = 1'b0;
        chk("t2_rsp_valid", rsp_valid, 4'b0100);
        chk("t2_rsp", {rsp_err, rsp_rdata}, {1'b0, 8'h3C});
        tick();
        chk("t2_rdata_hold", rsp_rdata, 8'h3C);

        // Reset clears response registers and pointer
        rst = 1'b1;
        #2;
        chk("rst2_rdata", rsp_rdata, 0);
        tick();
        rst = 1'b0;
        tick();

        // 3: all requesters held, order 0,1,2,3,0
        req_rnw = 4'b0000;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            got = '0;
            lowc = 0;
            for (int c = 0; c < 20; c++) begin
                if (send_en) break;
                if (req_ready != 4'b0) got = req_ready;
                lowc++;
                tick();
            end
            chk($sformatf("t3_grant%0d", k), got, exp_oh);
            chk($sformatf("t3_gap%0d", k), lowc >= 2, 1);
            repeat (3) tick();
            done = 1'b1;
            if (k == 4) req_valid = 4'h0;
            tick();
            done = 1'b0;
            chk($sformatf("t3_rsp%0d", k), {rsp_valid, send_en}, {exp_oh, 1'b0});
        end
        tick();

        // 4: timeout on 16-cycle instance
        b_req_dev_addr[7 +: 7] = 7'h21;
        b_req_rnw[1] = 1'b0;
        b_req_valid[1] = 1'b1;
        wait_rdy_b(got);
        chk("t4_ready", got, 4'b0010);
        b_req_valid[1] = 1'b0;
        tick();
        en_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!b_send_en) break;
            en_cnt++;
            tick();
        end
        chk("t4_en_cycles", en_cnt, 16);
        chk("t4_rsp_valid", b_rsp_valid, 4'b0010);
        chk("t4_rsp", {b_rsp_err, b_rsp_rdata}, {1'b1, 8'h00});

        // 5: done on the last allowed cycle wins over timeout
        b_req_rnw[3] = 1'b1;
        b_req_valid[3] = 1'b1;
        wait_rdy_b(got);
        chk("t5_ready", got, 4'b1000);
        b_req_valid[3] = 1'b0;
        tick();
        repeat (15) tick();
        chk("t5_still_run", b_recv_en, 1'b1);
        b_done = 1'b1; b_rd = 8'h9B;
        tick();
        b_done = 1'b0;
        chk("t5_rsp_valid", b_rsp_valid, 4'b1000);
        chk("t5_rsp", {b_rsp_err, b_rsp_rdata}, {1'b0, 8'h9B});

        // 6: reset mid-RUN
        req_rnw[0] = 1'b0;
        req_valid[0] = 1'b1;
        wait_rdy_a(got);
        chk("t6_ready", got, 4'b0001);
        req_valid[0] = 1'b0;
        repeat (4) tick();
        chk("t6_running", send_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_async_drop", {send_en, recv_en}, 0);
        seen = 1'b0;
        tick();
        rst = 1'b0;
        done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            seen |= (rsp_valid != 4'b0);
            tick();
            done = 1'b0;
        end
        seen |= (rsp_valid != 4'b0);
        chk("t6_no_rsp", seen, 1'b0);
        req_valid = 4'b0011;
        wait_rdy_a(got);
        chk("t6_ptr_reset", got, 4'b0001);
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
